mips_multicycle_core: RTL and testbench
=======================================

# mips_multicycle_core

- Parametrised multi-cycle core for the custom MIPS-style processor.
- Contains:
  - instruction memory with a program-load port;
  - data memory;
  - a general-purpose register file;
  - an ALU with a status-flag register;
  - a fetch/decode/execute/memory/writeback FSM.
- Replaces the fixed 16-bit, fixed-depth datapath with configurable width and depths.
- Adds multiply-high, load/store, branch/jump, halt and illegal-opcode handling.

## Interface
Parameters:
- DATA_W, 16, register/ALU width; must be ≥16.
- NREGS, 32, GPR count; power of 2, ≤32.
- IMEM_DEPTH, 64, instruction words; power of 2.
- DMEM_DEPTH, 64, data words; power of 2.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high.
- prog_we  in  1  instruction-memory write strobe; honoured only in IDLE or HALT.
- prog_addr  in  log2(IMEM_DEPTH)  write address.
- prog_data  in  32  instruction word.
- start  in  1  one-cycle pulse; honoured only in IDLE or HALT.
- dbg_addr  in  5  GPR index for debug read; low log2(NREGS) bits used.
- dbg_data  out  DATA_W  combinational GPR[dbg_addr].
- pc  out  log2(IMEM_DEPTH)  current PC.
- flags  out  5  {parity, overflow, carry, negative, zero}.
- busy  out  1  high in FETCH through WB.
- halted  out  1  high in HALT.
- illegal  out  1  sticky; set on undefined opcode.
- retire  out  1  one-cycle pulse in the last cycle of each completed instruction.

## Operation
Instruction fields:
- opcode IR[31:26]; rdst IR[25:21]; rsrc1 IR[20:16]; rsrc2 IR[15:11].
- imm and br_addr IR[15:0]; j_addr IR[25:0].
- Register indices use their low log2(NREGS) bits.
- imm is sign-extended to DATA_W.
- br_addr and j_addr use their low log2(IMEM_DEPTH) bits.

Opcodes:
- 00 ADD; 01 SUB; 02 AND; 03 OR; 04 XOR: rd = rs1 op rs2.
- 05 MUL: 2·DATA_W-bit unsigned product. rd = low half; internal mulhi = high half.
- 06 MOVI: rd = imm.
- 07 ADDI: rd = rs1 + imm.
- 08 LD: rd = dmem[(rs1+imm) mod DMEM_DEPTH].
- 09 ST: dmem[(rs1+imm) mod DMEM_DEPTH] = GPR[rdst].
- 0A BEQZ: if GPR[rsrc1]==0, PC = br_addr; else PC+1.
- 0B JMP: PC = j_addr.
- 0C MFHI: rd = mulhi.
- 3F HALT: go to HALT; PC is not advanced.
- Any other opcode: illegal=1, go to HALT.

GPR[0] rules:
- Always reads 0.
- Writes to it are discarded.

Flags (updated only by 00–05 and 07, at WB):
- zero = result==0; negative = result[DATA_W-1]; parity = XOR-reduce of result.
- carry: ADD/ADDI carry-out; SUB borrow (rs1<rs2 unsigned); MUL mulhi≠0; logic ops 0.
- overflow: signed overflow for ADD/ADDI/SUB; 0 otherwise.

FSM states and transitions:
- IDLE → FETCH on start.
- FETCH: IR ← imem[PC].
- DECODE: read operands.
- EXEC: ALU, branch/jump resolution, effective address.
  - LD/ST → MEM. ALU ops, MOVI, MFHI → WB.
  - BEQZ/JMP → FETCH with the new PC.
  - HALT/illegal → HALT.
- MEM: ST writes; LD captures data → WB.
- WB: register write, flags, PC+1 → FETCH.
- HALT → FETCH on start.

Program-counter and memory wrap:
- PC increments modulo IMEM_DEPTH; wraps from IMEM_DEPTH-1 to 0.
- Data addresses wrap modulo DMEM_DEPTH.

Start behaviour:
- start in IDLE/HALT: PC=0, illegal=0, registers and data memory retained.
- start in busy states: ignored.
- prog_we in busy states: ignored.
- prog_we and start in the same cycle: the write takes effect; the following FETCH sees the new word.

## Timing
Reset values (asynchronous):
- State=IDLE, PC=0, IR=0, all GPRs=0, mulhi=0, flags=0.
- busy=0, halted=0, illegal=0, retire=0.
- imem and dmem are not reset.

Reset mid-instruction:
- Aborts immediately; no partial register or memory write survives the reset edge.

Latency (start accepted at edge 0, FETCH in cycle 1):
- ALU ops, MOVI, MFHI: 4 cycles (FETCH, DECODE, EXEC, WB).
- LD/ST: 5 cycles.
- BEQZ/JMP: 3 cycles.
- HALT: 3 cycles; halted rises the cycle after EXEC.

retire timing:
- Asserted in WB for register-writing ops.
- Asserted in EXEC for BEQZ/JMP.
- Asserted in MEM for ST.
- Not asserted for HALT or illegal opcodes.

Visibility:
- Register writes are visible on dbg_data the cycle after WB.

## Test plan
- Load MOVI r1,5; MOVI r2,-3; ADD r3,r1,r2; HALT, then pulse start → r3=2, flags zero=0 carry=1 overflow=0, halted after 15 cycles, 3 retire pulses.
- DATA_W=16: MOVI r1,0x7FFF; ADDI r2,r1,1 → r2=0x8000, overflow=1, negative=1, parity=1; SUB r3,r0,r1 → carry=1.
- MUL of 0x1234 by 0x0100; MFHI r5 → low half=0x3400, r5=0x0012, carry=1.
- ST r4 → dmem[DMEM_DEPTH+2]; LD from address 2 → same value (wrap); ADD r0,r1,r1 → r0 stays 0.
- BEQZ taken to address 0 forms a loop; counter via ADDI/BEQZ exits after 3 iterations. JMP to IMEM_DEPTH-1 followed by a non-branch wraps the PC to 0.
- Opcode 0x2A → illegal=1, halted=1, no retire. Assert reset during an LD's MEM cycle → all outputs at reset values next cycle, target GPR unchanged (0).

Source files
------------

// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS-style core: imem with load port, dmem, GPR file,
// ALU + flag register, FETCH/DECODE/EXEC/MEM/WB control FSM.
// Ports: clk, reset (async, active-high), prog_we/prog_addr/prog_data
// (imem load), start, dbg_addr/dbg_data (GPR peek), pc, flags
// {parity,overflow,carry,negative,zero}, busy, halted, illegal, retire.
module mips_multicycle_core #(
  parameter int DATA_W     = 16,
  parameter int NREGS      = 32,
  parameter int IMEM_DEPTH = 64,
  parameter int DMEM_DEPTH = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          prog_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] prog_addr,
  input  logic [31:0]                   prog_data,
  input  logic                          start,
  input  logic [4:0]                    dbg_addr,
  output logic [DATA_W-1:0]             dbg_data,
  output logic [$clog2(IMEM_DEPTH)-1:0] pc,
  output logic [4:0]                    flags,
  output logic                          busy,
  output logic                          halted,
  output logic                          illegal,
  output logic                          retire
);
  localparam int RW = $clog2(NREGS);
  localparam int IW = $clog2(IMEM_DEPTH);
  localparam int AW = $clog2(DMEM_DEPTH);
  localparam int M  = DATA_W - 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_DEC   = 3'd2;
  localparam logic [2:0] S_EXEC  = 3'd3;
  localparam logic [2:0] S_MEM   = 3'd4;
  localparam logic [2:0] S_WB    = 3'd5;
  localparam logic [2:0] S_HALT  = 3'd6;

  localparam logic [5:0] OP_ADD  = 6'h00;
  localparam logic [5:0] OP_SUB  = 6'h01;
  localparam logic [5:0] OP_AND  = 6'h02;
  localparam logic [5:0] OP_OR   = 6'h03;
  localparam logic [5:0] OP_XOR  = 6'h04;
  localparam logic [5:0] OP_MUL  = 6'h05;
  localparam logic [5:0] OP_MOVI = 6'h06;
  localparam logic [5:0] OP_ADDI = 6'h07;
  localparam logic [5:0] OP_LD   = 6'h08;
  localparam logic [5:0] OP_ST   = 6'h09;
  localparam logic [5:0] OP_BEQZ = 6'h0A;
  localparam logic [5:0] OP_JMP  = 6'h0B;
  localparam logic [5:0] OP_MFHI = 6'h0C;
  localparam logic [5:0] OP_HALT = 6'h3F;

  logic [2:0]        state;
  logic [IW-1:0]     pc_r;
  logic [31:0]       ir;
  logic [DATA_W-1:0] gpr [NREGS];
  logic [31:0]       imem [IMEM_DEPTH];
  logic [DATA_W-1:0] dmem [DMEM_DEPTH];
  logic [DATA_W-1:0] mulhi, a, b, d, res, res_hi;
  logic [4:0]        fl, fl_x;
  logic [AW-1:0]     ea;
  logic              ill;

  logic [5:0]        op;
  logic [RW-1:0]     rd, rs1, rs2;
  logic [DATA_W-1:0] imm_x, bop, alu, hi;
  logic [DATA_W:0]   sum, dif;
  logic [2*DATA_W-1:0] prod;
  logic              cy, ov;
  logic              wr_op, fl_op, legal, idle;

  assign op    = ir[31:26];
  assign rd    = ir[21 +: RW];
  assign rs1   = ir[16 +: RW];
  assign rs2   = ir[11 +: RW];
  assign imm_x = DATA_W'($signed(ir[15:0]));
  assign wr_op = (op <= OP_LD) || (op == OP_MFHI);
  assign fl_op = (op <= OP_MUL) || (op == OP_ADDI);
  assign legal = (op <= OP_MFHI) || (op == OP_HALT);
  assign idle  = (state == S_IDLE) || (state == S_HALT);

  function automatic logic [DATA_W-1:0] rdg(
    input logic [RW-1:0] i
  );
    return (i == '0) ? '0 : gpr[i];
  endfunction

  // ADDI shares the adder; SUB borrow is the top bit of the extended diff
  assign bop  = (op == OP_ADDI) ? imm_x : b;
  assign sum  = {1'b0, a} + {1'b0, bop};
  assign dif  = {1'b0, a} - {1'b0, b};
  assign prod = (2*DATA_W)'(a) * (2*DATA_W)'(b);

  always_comb begin
    alu = '0;
    hi  = mulhi;
    cy  = 1'b0;
    ov  = 1'b0;
    case (op)
      OP_ADD, OP_ADDI: begin
        alu = sum[M:0];
        cy  = sum[DATA_W];
        ov  = (a[M] == bop[M]) && (sum[M] != a[M]);
      end
      OP_SUB: begin
        alu = dif[M:0];
        cy  = dif[DATA_W];
        ov  = (a[M] != b[M]) && (dif[M] != a[M]);
      end
      OP_AND:  alu = a & b;
      OP_OR:   alu = a | b;
      OP_XOR:  alu = a ^ b;
      OP_MUL: begin
        alu = prod[M:0];
        hi  = prod[2*DATA_W-1:DATA_W];
        cy  = |prod[2*DATA_W-1:DATA_W];
      end
      OP_MOVI: alu = imm_x;
      OP_MFHI: alu = mulhi;
      default: alu = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (prog_we && idle)
      imem[prog_addr] <= prog_data;
    if (state == S_MEM && op == OP_ST)
      dmem[ea] <= d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      pc_r   <= '0;
      ir     <= '0;
      mulhi  <= '0;
      fl     <= '0;
      fl_x   <= '0;
      ill    <= 1'b0;
      a      <= '0;
      b      <= '0;
      d      <= '0;
      res    <= '0;
      res_hi <= '0;
      ea     <= '0;
      for (int i = 0; i < NREGS; i++)
        gpr[i] <= '0;
    end else begin
      case (state)
        S_IDLE, S_HALT: begin
          if (start) begin
            state <= S_FETCH;
            pc_r  <= '0;
            ill   <= 1'b0;
          end
        end
        S_FETCH: begin
          ir    <= imem[pc_r];
          state <= S_DEC;
        end
        S_DEC: begin
          a     <= rdg(rs1);
          b     <= rdg(rs2);
          d     <= rdg(rd);
          state <= S_EXEC;
        end
        S_EXEC: begin
          res    <= alu;
          res_hi <= hi;
          fl_x   <= {^alu, ov, cy, alu[M], alu == '0};
          ea     <= AW'(a + imm_x);
          if (op == OP_LD || op == OP_ST) begin
            state <= S_MEM;
          end else if (op == OP_BEQZ) begin
            pc_r  <= (a == '0) ? ir[IW-1:0] : pc_r + IW'(1);
            state <= S_FETCH;
          end else if (op == OP_JMP) begin
            pc_r  <= ir[IW-1:0];
            state <= S_FETCH;
          end else if (!legal) begin
            ill   <= 1'b1;
            state <= S_HALT;
          end else if (op == OP_HALT) begin
            state <= S_HALT;
          end else begin
            state <= S_WB;
          end
        end
        S_MEM: begin
          if (op == OP_LD)
            res <= dmem[ea];
          state <= S_WB;
        end
        S_WB: begin
          if (wr_op && rd != '0)
            gpr[rd] <= res;
          if (fl_op)
            fl <= fl_x;
          if (op == OP_MUL)
            mulhi <= res_hi;
          pc_r  <= pc_r + IW'(1);
          state <= S_FETCH;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign dbg_data = rdg(dbg_addr[RW-1:0]);
  assign pc       = pc_r;
  assign flags    = fl;
  assign busy     = (state >= S_FETCH) && (state <= S_WB);
  assign halted   = (state == S_HALT);
  assign illegal  = ill;
  assign retire   = ((state == S_WB) && wr_op)
                 || ((state == S_EXEC) && (op == OP_BEQZ || op == OP_JMP))
                 || ((state == S_MEM) && (op == OP_ST));
endmodule

// File: tb/tb_mips_multicycle_core.sv
// Scoreboard bench for mips_multicycle_core: directed programs,
// retire/halt events checked by a monitor against queued expectations.
module tb_mips_multicycle_core;
  logic        clk = 1'b0;
  logic        reset, prog_we, start;
  logic [5:0]  prog_addr;
  logic [31:0] prog_data;
  logic [4:0]  dbg_addr;
  logic [15:0] dbg_data;
  logic [5:0]  pc;
  logic [4:0]  flags;
  logic        busy, halted, illegal, retire;

  mips_multicycle_core dut (
    .clk(clk), .reset(reset), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data),
    .start(start), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .pc(pc), .flags(flags), .busy(busy), .halted(halted),
    .illegal(illegal), .retire(retire)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         h;
    logic [5:0] pc;
    logic [4:0] fl;
    bit         ill;
    int         lat;
  } exp_t;

  exp_t q[$];
  int n_chk = 0, n_pass = 0, nh = 0, cyc = 0, t0 = 0;
  logic hq = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endfunction

  function automatic void er(logic [5:0] p);
    exp_t e;
    e.h = 0; e.pc = p; e.fl = '0; e.ill = 0; e.lat = -1;
    q.push_back(e);
  endfunction

  function automatic void eh(logic [5:0] p, logic [4:0] f,
                             bit il, int lat);
    exp_t e;
    e.h = 1; e.pc = p; e.fl = f; e.ill = il; e.lat = lat;
    q.push_back(e);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (retire) begin
        if (q.size() == 0 || q[0].h) begin
          n_chk++;
          $display("FAIL retire: unexpected at pc %0d", pc);
        end else begin
          e = q.pop_front();
          chk("retire_pc", {26'd0, pc}, {26'd0, e.pc});
        end
      end
      if (halted && !hq) begin
        while (q.size() > 0 && !q[0].h) begin
          n_chk++;
          $display("FAIL retire: missing pc %0d", q[0].pc);
          void'(q.pop_front());
        end
        if (q.size() == 0) begin
          n_chk++;
          $display("FAIL halt: unexpected at pc %0d", pc);
        end else begin
          e = q.pop_front();
          chk("halt_pc", {26'd0, pc}, {26'd0, e.pc});
          chk("halt_flags", {27'd0, flags}, {27'd0, e.fl});
          chk("halt_illegal", {31'd0, illegal}, {31'd0, e.ill});
          if (e.lat >= 0) chk("halt_lat", cyc - t0, e.lat);
        end
        nh++;
      end
    end
    hq <= halted;
  end

  function automatic logic [31:0] rr(int o, int d, int s1, int s2);
    return {o[5:0], d[4:0], s1[4:0], s2[4:0], 11'd0};
  endfunction

  function automatic logic [31:0] ii(int o, int d, int s1, int im);
    return {o[5:0], d[4:0], s1[4:0], im[15:0]};
  endfunction

  localparam logic [31:0] HLT = {6'h3F, 26'd0};

  task automatic ld(int a, logic [31:0] w);
    @(negedge clk);
    prog_we = 1'b1; prog_addr = a[5:0]; prog_data = w;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  // word 0 is written in the same cycle start is accepted
  task automatic go(logic [31:0] w0);
    @(negedge clk);
    prog_we = 1'b1; prog_addr = 6'd0; prog_data = w0;
    start = 1'b1;
    t0 = cyc + 1;
    @(negedge clk);
    prog_we = 1'b0; start = 1'b0;
  endtask

  task automatic wait_halt();
    int tgt;
    tgt = nh + 1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (nh >= tgt) break;
    end
    if (nh < tgt) begin
      n_chk++;
      $display("FAIL timeout: halted not seen, %0d entries left",
               q.size());
      q.delete();
    end
  endtask

  task automatic rg(int r, logic [15:0] v);
    dbg_addr = r[4:0];
    #1;
    chk($sformatf("r%0d", r), {16'd0, dbg_data}, {16'd0, v});
  endtask

  initial begin
    reset = 1'b1; prog_we = 1'b0; start = 1'b0;
    prog_addr = '0; prog_data = '0; dbg_addr = '0;
    repeat (2) @(negedge clk);
    chk("rst_pc", {26'd0, pc}, 32'd0);
    chk("rst_flags", {27'd0, flags}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    chk("rst_retire", {31'd0, retire}, 32'd0);
    reset = 1'b0;

    // 5 + -3: carry out, no overflow
    ld(1, ii(6, 2, 0, -3));
    ld(2, rr(0, 3, 1, 2));
    ld(3, HLT);
    er(0); er(1); er(2); eh(3, 5'b10100, 0, 15);
    go(ii(6, 1, 0, 5));
    wait_halt();
    rg(3, 16'h0002); rg(2, 16'hFFFD); rg(1, 16'h0005);

    // signed overflow on ADDI
    ld(1, ii(7, 2, 1, 1));
    ld(2, HLT);
    er(0); er(1); eh(2, 5'b11010, 0, 11);
    go(ii(6, 1, 0, 16'h7FFF));
    wait_halt();
    rg(2, 16'h8000);

    // 0 - 0x7FFF: borrow, no overflow
    ld(2, rr(1, 3, 0, 1));
    ld(3, HLT);
    er(0); er(1); er(2); eh(3, 5'b00110, 0, 15);
    go(ii(6, 1, 0, 16'h7FFF));
    wait_halt();
    rg(3, 16'h8001);

    // MUL / MFHI
    ld(1, ii(6, 2, 0, 16'h0100));
    ld(2, rr(5, 4, 1, 2));
    ld(3, rr(12, 5, 0, 0));
    ld(4, HLT);
    er(0); er(1); er(2); er(3); eh(4, 5'b10100, 0, 19);
    go(ii(6, 1, 0, 16'h1234));
    wait_halt();
    rg(4, 16'h3400); rg(5, 16'h0012);

    // ST to 66 wraps to 2; LD 2; write to r0 discarded
    ld(1, ii(9, 4, 6, 0));
    ld(2, ii(8, 8, 0, 2));
    ld(3, rr(0, 0, 1, 1));
    ld(4, HLT);
    er(0); er(1); er(2); er(3); eh(4, 5'b10000, 0, 21);
    go(ii(6, 6, 0, 66));
    wait_halt();
    rg(8, 16'h3400); rg(0, 16'h0000);

    // counter loop: r9 = 3, ADDI -1 / BEQZ exit / BEQZ r0 -> 0
    ld(1, HLT);
    er(0); eh(1, 5'b10000, 0, 7);
    go(ii(6, 9, 0, 3));
    wait_halt();
    ld(1, ii(10, 0, 9, 3));
    ld(2, ii(10, 0, 0, 0));
    ld(3, HLT);
    for (int k = 0; k < 2; k++) begin
      er(0); er(1); er(2);
    end
    er(0); er(1); eh(3, 5'b00101, 0, 30);
    go(ii(7, 9, 9, -1));
    wait_halt();
    rg(9, 16'h0000);

    // JMP 63, ADDI at 63 wraps PC to 0
    ld(1, HLT);
    ld(2, {6'h0B, 26'd63});
    ld(63, ii(7, 10, 10, 1));
    er(0); er(2); er(63); er(0); eh(1, 5'b10000, 0, 16);
    go(ii(10, 0, 10, 2));
    wait_halt();
    rg(10, 16'h0001);

    // undefined opcode 0x2A
    eh(0, 5'b10000, 1, 3);
    go({6'h2A, 26'd0});
    wait_halt();

    // reset during an LD's MEM cycle
    ld(1, HLT);
    go(ii(8, 14, 0, 2));
    chk("start_clears_illegal", {31'd0, illegal}, 32'd0);
    repeat (3) @(negedge clk);
    chk("mem_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("mrst_pc", {26'd0, pc}, 32'd0);
    chk("mrst_flags", {27'd0, flags}, 32'd0);
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_halted", {31'd0, halted}, 32'd0);
    chk("mrst_illegal", {31'd0, illegal}, 32'd0);
    chk("mrst_retire", {31'd0, retire}, 32'd0);
    rg(14, 16'h0000); rg(4, 16'h0000);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("q_empty", q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
